// File: rtl/addr_bus_arbiter_if.sv
// Handshake and bus signals shared between the two requesters and the address arbiter.
interface addr_bus_arbiter_if #(
  parameter int ADDR_W = 14
);
  logic              req_0;
  logic [ADDR_W-1:0] addr_0;
  logic              req_1;
  logic [ADDR_W-1:0] addr_1;
  logic              gnt_0;
  logic              gnt_1;
  logic [1:0]        sel;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_valid;

  modport master (
    output req_0, addr_0, req_1, addr_1,
    input  gnt_0, gnt_1, sel, bus_addr, bus_valid
  );

  modport slave (
    input  req_0, addr_0, req_1, addr_1,
    output gnt_0, gnt_1, sel, bus_addr, bus_valid
  );
endinterface

// File: rtl/addr_bus_arbiter.sv
// Two-requester round-robin arbiter for the shared address/control bus, with a hold
// counter bounding ownership under contention and a registered copy of the owner address.
module addr_bus_arbiter #(
  parameter int ADDR_W   = 14,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  addr_bus_arbiter_if.slave bus
);

  // State encoding doubles as the mux select value, so sel is a direct copy of the state.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

  state_t            state_r;
  state_t            next_state_s;
  logic              last_r;
  logic [7:0]        hold_cnt_r;
  logic [ADDR_W-1:0] bus_addr_r;
  logic              hold_done_s;

  assign hold_done_s = (hold_cnt_r == MAX_HOLD_C);

  // State, last owner, hold counter and registered owner address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      last_r     <= 1'b1;
      hold_cnt_r <= 8'd0;
      bus_addr_r <= '0;
    end else begin
      state_r <= next_state_s;
      case (next_state_s)
        OWN0: begin
          last_r     <= 1'b0;
          bus_addr_r <= bus.addr_0;
        end
        OWN1: begin
          last_r     <= 1'b1;
          bus_addr_r <= bus.addr_1;
        end
        default: begin
          last_r     <= last_r;
          bus_addr_r <= '0;
        end
      endcase
      if (next_state_s == IDLE) begin
        hold_cnt_r <= 8'd0;
      end else if (next_state_s != state_r) begin
        hold_cnt_r <= 8'd1;
      end else if (hold_cnt_r < MAX_HOLD_C) begin
        hold_cnt_r <= hold_cnt_r + 8'd1;
      end else begin
        hold_cnt_r <= hold_cnt_r;
      end
    end
  end

  // Next-state decision: round-robin from idle, direct handover or bounded hold while owned.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.req_0 && bus.req_1) begin
          next_state_s = last_r ? OWN0 : OWN1;
        end else if (bus.req_0) begin
          next_state_s = OWN0;
        end else if (bus.req_1) begin
          next_state_s = OWN1;
        end else begin
          next_state_s = IDLE;
        end
      end
      OWN0: begin
        if (!bus.req_0) begin
          next_state_s = bus.req_1 ? OWN1 : IDLE;
        end else if (bus.req_1 && hold_done_s) begin
          next_state_s = OWN1;
        end else begin
          next_state_s = OWN0;
        end
      end
      OWN1: begin
        if (!bus.req_1) begin
          next_state_s = bus.req_0 ? OWN0 : IDLE;
        end else if (bus.req_0 && hold_done_s) begin
          next_state_s = OWN0;
        end else begin
          next_state_s = OWN1;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Output decode straight from the state register keeps grants glitch-free.
  always_comb begin
    bus.gnt_0     = 1'b0;
    bus.gnt_1     = 1'b0;
    bus.sel       = 2'd0;
    bus.bus_valid = 1'b0;
    bus.bus_addr  = bus_addr_r;
    case (state_r)
      OWN0: begin
        bus.gnt_0     = 1'b1;
        bus.sel       = 2'd1;
        bus.bus_valid = 1'b1;
      end
      OWN1: begin
        bus.gnt_1     = 1'b1;
        bus.sel       = 2'd2;
        bus.bus_valid = 1'b1;
      end
      default: begin
        bus.gnt_0     = 1'b0;
        bus.gnt_1     = 1'b0;
        bus.sel       = 2'd0;
        bus.bus_valid = 1'b0;
      end
    endcase
  end

endmodule
